// File: rtl/and8_share_arbiter_if.sv
// Bundle between the requesting control blocks, the arbiter and the shared AND-8 unit.
// The arbiter takes the slave view; the requester/unit environment takes the master view.
interface and8_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] in_data;
  logic [7:0]        and_in;
  logic              and_out;
  logic [NREQ-1:0]   ack;
  logic              result;
  logic [ID_W-1:0]   result_id;
  logic              busy;

  modport slave (
    input  req, in_data, and_out,
    output and_in, ack, result, result_id, busy
  );

  modport master (
    output req, in_data, and_out,
    input  and_in, ack, result, result_id, busy
  );
endinterface

// File: rtl/and8_share_arbiter.sv
// Round-robin time-sharing of one external AND-8 reduction unit among NREQ requesters.
// Each operation is a fixed IDLE -> EVAL -> RESP sequence with a one-cycle ack.
module and8_share_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic clock,
  input  logic reset,
  and8_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_reg;
  logic [ID_W-1:0] winner;
  logic [7:0]      op_reg;
  logic            result_reg;

  // First set request at or after ptr, wrapping around.
  function automatic logic [ID_W-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                  input logic [ID_W-1:0] p);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] w);
    if (int'(w) >= NREQ - 1) return '0;
    return w + 1'b1;
  endfunction

  assign winner     = pick_winner(bus.req, ptr);
  // op_reg feeds the shared unit directly, so and_in holds its last operand in IDLE.
  assign bus.and_in = op_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      win_reg    <= '0;
      op_reg     <= '0;
      result_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win_reg <= winner;
            op_reg  <= bus.in_data[int'(winner)*8 +: 8];
          end
        end
        EVAL:    result_reg <= bus.and_out;
        RESP:    ptr        <= next_ptr(win_reg);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.ack       = '0;
    bus.result    = 1'b0;
    bus.result_id = '0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: if (|bus.req) state_nxt = EVAL;
      EVAL: state_nxt = RESP;
      RESP: begin
        bus.ack[win_reg] = 1'b1;
        bus.result       = result_reg;
        bus.result_id    = win_reg;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_and8_share_arbiter.sv
// Randomised self-checking bench for and8_share_arbiter against a round-robin reference model.
module tb_and8_share_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  and8_share_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();
  assign bus.and_out = &bus.and_in;

  and8_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         passes = 0;
  int         m_ptr  = 0;
  logic [7:0] m_last = 8'h00;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference arbitration: scan ptr, ptr+1, ... modulo NREQ for the first requester.
  function automatic int model_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [7:0] rand_operand();
    logic [7:0] v;
    case ($urandom_range(0, 2))
      0:       v = 8'hFF;
      1:       v = 8'hFF & ~(8'h01 << $urandom_range(0, 7));
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // One full operation from IDLE: grant, evaluate, respond, back to IDLE.
  task automatic serve_op(input logic [NREQ-1:0] r, input int exp_id,
                          input bit drop_in_eval, input bit keep_req, input string tag);
    logic [7:0]      op;
    logic            exp_res;
    logic [NREQ-1:0] exp_ack;
    op      = bus.in_data[8*exp_id +: 8];
    exp_res = &op;
    exp_ack = NREQ'(1) << exp_id;
    bus.req = r;
    tick();
    checks++; if (bus.busy !== 1'b1) $display("FAIL %s_eval_busy: got %b want 1", tag, bus.busy); else passes++;
    checks++; if (bus.ack !== '0) $display("FAIL %s_eval_ack: got %b want 0000", tag, bus.ack); else passes++;
    checks++; if (bus.and_in !== op) $display("FAIL %s_eval_and_in: got %h want %h", tag, bus.and_in, op); else passes++;
    if (drop_in_eval) begin
      bus.req     = '0;
      bus.in_data = ~bus.in_data;
    end
    tick();
    checks++; if (bus.ack !== exp_ack) $display("FAIL %s_ack: got %b want %b", tag, bus.ack, exp_ack); else passes++;
    checks++; if (bus.result !== exp_res) $display("FAIL %s_result: got %b want %b", tag, bus.result, exp_res); else passes++;
    checks++; if (bus.result_id !== ID_W'(exp_id)) $display("FAIL %s_result_id: got %0d want %0d", tag, bus.result_id, exp_id); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL %s_resp_busy: got %b want 1", tag, bus.busy); else passes++;
    m_ptr  = (exp_id + 1) % NREQ;
    m_last = op;
    if (!keep_req) bus.req = '0;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL %s_idle_busy: got %b want 0", tag, bus.busy); else passes++;
    checks++; if (bus.ack !== '0) $display("FAIL %s_idle_ack: got %b want 0000", tag, bus.ack); else passes++;
    checks++; if (bus.and_in !== m_last) $display("FAIL %s_idle_and_in: got %h want %h", tag, bus.and_in, m_last); else passes++;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.req     = '0;
    bus.in_data = '0;
    #1;
    checks++; if (bus.and_in !== 8'h00) $display("FAIL reset_and_in: got %h want 00", bus.and_in); else passes++;
    checks++; if (bus.ack !== '0) $display("FAIL reset_ack: got %b want 0000", bus.ack); else passes++;
    checks++; if (bus.result !== 1'b0) $display("FAIL reset_result: got %b want 0", bus.result); else passes++;
    checks++; if (bus.result_id !== '0) $display("FAIL reset_result_id: got %0d want 0", bus.result_id); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
    tick();
    tick();
    reset  = 1'b0;
    m_ptr  = 0;
    m_last = 8'h00;
  endtask

  task automatic test_single();
    bus.in_data[8*2 +: 8] = 8'hFF;
    serve_op(4'b0100, model_winner(4'b0100, m_ptr), 1'b0, 1'b0, "single_ff");
    bus.in_data[8*0 +: 8] = 8'hFE;
    serve_op(4'b0001, model_winner(4'b0001, m_ptr), 1'b0, 1'b0, "single_fe");
  endtask

  task automatic test_all_req();
    int seq [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ptr  = 0;
    m_last = 8'h00;
    for (int i = 0; i < NREQ; i++) bus.in_data[8*i +: 8] = rand_operand();
    for (int n = 0; n < 5; n++)
      serve_op(4'b1111, seq[n], 1'b0, (n < 4), "all_req");
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] reqs [4] = '{4'b0100, 4'b1001, 4'b1001, 4'b0011};
    int              ids  [4] = '{2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) bus.in_data[8*i +: 8] = rand_operand();
    for (int n = 0; n < 4; n++)
      serve_op(reqs[n], ids[n], 1'b0, (n == 1), "wrap");
  endtask

  task automatic test_reset_mid_op();
    bus.in_data[8*2 +: 8] = 8'hFF;
    serve_op(4'b0100, model_winner(4'b0100, m_ptr), 1'b0, 1'b0, "pre_rst");
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.busy !== 1'b1) $display("FAIL rstmid_eval_busy: got %b want 1", bus.busy); else passes++;
    #1;
    reset   = 1'b1;
    bus.req = '0;
    #1;
    checks++; if (bus.and_in !== 8'h00) $display("FAIL rstmid_and_in: got %h want 00", bus.and_in); else passes++;
    checks++; if (bus.ack !== '0) $display("FAIL rstmid_ack: got %b want 0000", bus.ack); else passes++;
    checks++; if (bus.result !== 1'b0) $display("FAIL rstmid_result: got %b want 0", bus.result); else passes++;
    checks++; if (bus.result_id !== '0) $display("FAIL rstmid_result_id: got %0d want 0", bus.result_id); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else passes++;
    tick();
    reset  = 1'b0;
    m_ptr  = 0;
    m_last = 8'h00;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++; if (bus.ack !== '0) $display("FAIL rstmid_no_ack: got %b want 0000", bus.ack); else passes++;
    end
    for (int i = 0; i < NREQ; i++) bus.in_data[8*i +: 8] = rand_operand();
    serve_op(4'b1001, model_winner(4'b1001, m_ptr), 1'b0, 1'b0, "post_rst_ptr");
    serve_op(4'b0010, model_winner(4'b0010, m_ptr), 1'b0, 1'b0, "post_rst_id1");
  endtask

  task automatic test_drop_req();
    bus.in_data[8*1 +: 8] = 8'hFF;
    serve_op(4'b0010, 1, 1'b1, 1'b0, "drop_ff");
    bus.in_data[8*1 +: 8] = 8'h7F;
    serve_op(4'b0010, 1, 1'b1, 1'b0, "drop_7f");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    for (int n = 0; n < 60; n++) begin
      r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) bus.in_data[8*i +: 8] = rand_operand();
      if (r == '0) begin
        bus.req = '0;
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL rand_idle_busy: got %b want 0", bus.busy); else passes++;
        checks++; if (bus.ack !== '0) $display("FAIL rand_idle_ack: got %b want 0000", bus.ack); else passes++;
        checks++; if (bus.and_in !== m_last) $display("FAIL rand_idle_hold: got %h want %h", bus.and_in, m_last); else passes++;
      end else begin
        serve_op(r, model_winner(r, m_ptr), 1'($urandom_range(0, 1)), 1'b0, "rand");
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_wrap();
    test_reset_mid_op();
    test_drop_req();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
